sd_image_reader: RTL
====================

Name: sd_image_reader

Overview:
- Read-path sequencer for the SD card subsystem; the counterpart of the image-write sequencer.
- On an image read request it issues consecutive single-sector reads to the SD controller's user read interface.
- It forwards each 16-bit read word into the 16-bit-write/32-bit-read image FIFO toward DDR and reports image completion.
- Flow control: a sector read starts only when the FIFO has room for a whole sector.

Parameters:
IMAGE_START_SEC, 32'd16000, first sector address of the stored image
IMAGE_SEC_NUM, 1200, sectors per image (640x480x16 bit / 512 bytes)
SEC_WORDS, 256, 16-bit words per sector
FIFO_DEPTH, 2048, write-side depth of the target FIFO in 16-bit words
FIFO_LEN_W, 11, width of the FIFO write-side fill count

Ports:
clk  in  1  SD reference clock, same clock as the SD controller user interface
rst  in  1  synchronous, active-high reset
sd_init_done  in  1  SD card initialised
image_read_req  in  1  read request level; its rising edge starts an image read
rd_busy  in  1  SD controller read busy
rd_val_en  in  1  read data valid strobe
rd_val_data  in  16  read data word
rd_start_en  out  1  one-cycle sector read start pulse
rd_sec_addr  out  32  sector address to read
fifo_full  in  1  FIFO full flag (write side)
fifo_len  in  FIFO_LEN_W  FIFO fill count (write side)
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  16  FIFO write data
reader_busy  out  1  image transfer in progress
image_done_n  out  1  low after an image is completely read
sec_err  out  1  sticky: some sector delivered a word count other than SEC_WORDS
ovf_err  out  1  sticky: a write was presented while fifo_full=1

Behaviour:
- Reset values:
  - rd_start_en, fifo_wr_en, reader_busy, sec_err, ovf_err = 0.
  - rd_sec_addr = IMAGE_START_SEC; fifo_wr_data = 0; image_done_n = 1.
  - State = IDLE; sector count = 0; word count = 0; request-edge register = 0.
- Request edge: image_read_req is registered once; edge = req & ~req_d1.
- IDLE:
  - On edge with sd_init_done=1: sector count=0, image_done_n=1, sec_err=0, ovf_err=0, reader_busy=1, go to WAIT_SPACE.
  - An edge while sd_init_done=0 is dropped.
  - Edges outside IDLE are ignored.
- WAIT_SPACE: go to START when rd_busy=0 AND fifo_full=0 AND fifo_len <= FIFO_DEPTH-SEC_WORDS (1792 at defaults).
- START:
  - rd_start_en=1 for exactly one cycle.
  - rd_sec_addr = IMAGE_START_SEC + sector count; the address is held stable until the next START.
  - Word count cleared; go to WAIT_BUSY.
- WAIT_BUSY: go to RECV on rd_busy=1.
- RECV:
  - Each rd_val_en increments the word count. The count is 9 bits and saturates at 511.
  - On rd_busy=0: if word count != SEC_WORDS, set sec_err. Then go to NEXT.
- NEXT:
  - If sector count = IMAGE_SEC_NUM-1, go to DONE.
  - Otherwise increment sector count and go to WAIT_SPACE.
- DONE: image_done_n=0, reader_busy=0, go to IDLE. image_done_n stays 0 until the next accepted request.
- Data path, one-cycle latency:
  - fifo_wr_en <= rd_val_en when state is WAIT_BUSY or RECV; fifo_wr_data <= rd_val_data.
  - rd_val_en in any other state is dropped and not counted.
  - If fifo_wr_en=1 while fifo_full=1: set ovf_err. The write is still presented; the FIFO discards it.
- Simultaneous events:
  - rd_val_en in the same cycle as rd_busy falling: the word is written and counted before the count check.
  - An edge in the same cycle as DONE is ignored.
- Arithmetic: sector address is a 32-bit add, wrap permitted; the sector count is 16 bits.
- Reset mid-transfer: immediate return to IDLE with all outputs at reset values. Any in-flight controller read is drained by the rd_busy=0 wait in WAIT_SPACE before the next START.
- sd_init_done is sampled only in IDLE.

Test Plan:
- Bench parameters: IMAGE_START_SEC=100, IMAGE_SEC_NUM=3; controller model returns 256 words per sector, data = address[7:0]<<8 | index.
- Nominal: fifo_len=0, req rises -> three rd_start_en pulses with rd_sec_addr 100, 101, 102; 768 fifo_wr_en pulses, each 1 cycle after rd_val_en with matching data; image_done_n falls after the third rd_busy fall; sec_err=0, ovf_err=0.
- Backpressure: fifo_len=1800 at request -> no rd_start_en; drop fifo_len to 1792 -> START the next cycle after WAIT_SPACE evaluates; data intact.
- Short sector: model gives 255 words on sector 101 -> sec_err=1 sticky, 767 writes, image_done_n=0; next request clears sec_err.
- Gating and re-trigger: req with sd_init_done=0 -> no activity; second req edge mid-image -> ignored (exactly 3 sectors); req held high after done -> no restart until it toggles.
- Overflow: fifo_full forced 1 during RECV -> ovf_err=1, transfer still completes.
- Reset: rst asserted for 1 cycle in RECV of sector 101 with rd_busy still high -> all outputs at reset values next cycle; a new request waits for rd_busy=0, then restarts at sector 100.

Source files
------------

// File: rtl/sd_image_reader.sv
// sd_image_reader
//   Read-path sequencer for the SD card subsystem. On a rising edge of
//   image_read_req it reads IMAGE_SEC_NUM consecutive sectors, starting at
//   IMAGE_START_SEC, through the SD controller's single-sector read interface.
//   Every received 16-bit word goes to the image FIFO (toward DDR) one cycle
//   later. A sector read starts only when the FIFO has room for a whole sector.
//
// Ports
//   clk, rst          : SD reference clock, synchronous active-high reset
//   sd_init_done      : card initialised; only checked when a request arrives
//   image_read_req    : request level; its rising edge starts an image read
//   rd_busy           : controller read busy
//   rd_val_en/_data   : controller read data strobe and word
//   rd_start_en       : one-cycle sector read start pulse
//   rd_sec_addr       : sector address, held stable between starts
//   fifo_full/_len    : FIFO write-side full flag and fill count
//   fifo_wr_en/_data  : FIFO write port
//   reader_busy       : image transfer in progress
//   image_done_n      : low once an image is complete, until the next request
//   sec_err           : sticky, a sector delivered a word count != SEC_WORDS
//   ovf_err           : sticky, a write was presented while fifo_full was set
module sd_image_reader #(
  parameter logic [31:0] IMAGE_START_SEC = 32'd16000,
  parameter int unsigned IMAGE_SEC_NUM   = 1200,
  parameter int unsigned SEC_WORDS       = 256,
  parameter int unsigned FIFO_DEPTH      = 2048,
  parameter int unsigned FIFO_LEN_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sd_init_done,
  input  logic                  image_read_req,
  input  logic                  rd_busy,
  input  logic                  rd_val_en,
  input  logic [15:0]           rd_val_data,
  output logic                  rd_start_en,
  output logic [31:0]           rd_sec_addr,
  input  logic                  fifo_full,
  input  logic [FIFO_LEN_W-1:0] fifo_len,
  output logic                  fifo_wr_en,
  output logic [15:0]           fifo_wr_data,
  output logic                  reader_busy,
  output logic                  image_done_n,
  output logic                  sec_err,
  output logic                  ovf_err
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_SPACE = 3'd1;
  localparam logic [2:0] START      = 3'd2;
  localparam logic [2:0] WAIT_BUSY  = 3'd3;
  localparam logic [2:0] RECV       = 3'd4;
  localparam logic [2:0] NEXT       = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;

  localparam int unsigned SPACE_LIMIT = FIFO_DEPTH - SEC_WORDS;
  localparam logic [15:0] LAST_SEC    = 16'(IMAGE_SEC_NUM - 1);
  localparam logic [8:0]  SEC_WORDS_C = 9'(SEC_WORDS);
  localparam logic [8:0]  WORD_MAX    = '1;

  logic [2:0]  state;
  logic [15:0] sec_cnt;
  logic [8:0]  word_cnt;
  logic [8:0]  word_cnt_next;
  logic        req_d1;
  logic        req_edge;
  logic        space_ok;
  logic        data_phase;
  logic        take_word;

  assign req_edge   = image_read_req & ~req_d1;
  assign space_ok   = !rd_busy && !fifo_full && (32'(fifo_len) <= SPACE_LIMIT);
  assign data_phase = (state == WAIT_BUSY) || (state == RECV);
  assign take_word  = data_phase && rd_val_en;

  // Count including the word arriving this cycle, so a word that coincides
  // with the rd_busy fall is part of the end-of-sector length check.
  always_comb begin
    word_cnt_next = word_cnt;
    if (take_word && (word_cnt != WORD_MAX)) begin
      word_cnt_next = word_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sec_cnt      <= '0;
      word_cnt     <= '0;
      req_d1       <= 1'b0;
      rd_start_en  <= 1'b0;
      rd_sec_addr  <= IMAGE_START_SEC;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      reader_busy  <= 1'b0;
      image_done_n <= 1'b1;
      sec_err      <= 1'b0;
      ovf_err      <= 1'b0;
    end else begin
      req_d1      <= image_read_req;
      rd_start_en <= 1'b0;
      fifo_wr_en  <= take_word;
      if (take_word) begin
        fifo_wr_data <= rd_val_data;
      end
      word_cnt <= word_cnt_next;
      if (fifo_wr_en && fifo_full) begin
        ovf_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_edge && sd_init_done) begin
            sec_cnt      <= '0;
            image_done_n <= 1'b1;
            sec_err      <= 1'b0;
            ovf_err      <= 1'b0;
            reader_busy  <= 1'b1;
            state        <= WAIT_SPACE;
          end
        end
        // The rd_busy=0 condition also drains a read left in flight by a reset.
        WAIT_SPACE: begin
          if (space_ok) begin
            rd_start_en <= 1'b1;
            rd_sec_addr <= IMAGE_START_SEC + {16'b0, sec_cnt};
            state       <= START;
          end
        end
        START: begin
          word_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (rd_busy) begin
            state <= RECV;
          end
        end
        RECV: begin
          if (!rd_busy) begin
            if (word_cnt_next != SEC_WORDS_C) begin
              sec_err <= 1'b1;
            end
            state <= NEXT;
          end
        end
        NEXT: begin
          if (sec_cnt == LAST_SEC) begin
            state <= DONE;
          end else begin
            sec_cnt <= sec_cnt + 16'd1;
            state   <= WAIT_SPACE;
          end
        end
        DONE: begin
          image_done_n <= 1'b0;
          reader_busy  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
